// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: NREQ sources share one registered RF write port,
// plus a 32-entry pending-write scoreboard. Define RF_ARB_FIXED_PRIO_EN for fixed priority.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_waddr,
  input  logic [NREQ*XLEN-1:0] req_wdata,
  input  logic                 iss_valid,
  input  logic                 iss_wen,
  input  logic [AW-1:0]        iss_rd,
  input  logic [AW-1:0]        iss_rs1,
  input  logic [AW-1:0]        iss_rs2,
  output logic                 iss_stall,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic [31:0]          busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = PW + 1;

  logic [PW-1:0]   w_ptr;
  logic [CW-1:0]   w_cand;
  logic            w_grant_vld;
  logic [PW-1:0]   w_grant_idx;
  logic [PW-1:0]   w_ptr_nxt;
  logic [AW-1:0]   w_sel_waddr;
  logic [XLEN-1:0] w_sel_wdata;
  logic            w_iss_accept;
  logic [31:0]     w_busy_nxt;

  logic            r_rf_wen;
  logic [AW-1:0]   r_rf_waddr;
  logic [XLEN-1:0] r_rf_wdata;
  logic [31:0]     r_busy;

`ifdef RF_ARB_FIXED_PRIO_EN
  assign w_ptr = '0;
`else
  logic [PW-1:0] r_rr_ptr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            r_rr_ptr <= '0;
    else if (w_grant_vld) r_rr_ptr <= w_ptr_nxt;
  end

  assign w_ptr = r_rr_ptr;
`endif

  // Scan cyclically from w_ptr; the first valid source found wins.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, w_ptr} + CW'(k);
      if (w_cand >= CW'(NREQ)) w_cand = w_cand - CW'(NREQ);
      if (!w_grant_vld && req_valid[w_cand[PW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready   = '0;
    w_sel_waddr = '0;
    w_sel_wdata = '0;
    if (w_grant_vld) req_ready[w_grant_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == PW'(i)) begin
        w_sel_waddr = req_waddr[i*AW +: AW];
        w_sel_wdata = req_wdata[i*XLEN +: XLEN];
      end
    end
  end

  assign w_ptr_nxt = (w_grant_idx == PW'(NREQ - 1)) ? '0 : w_grant_idx + PW'(1);

  // Writes to x0 are consumed here but never raise rf_wen.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_grant_vld) begin
      r_rf_wen   <= (w_sel_waddr != '0);
      r_rf_waddr <= w_sel_waddr;
      r_rf_wdata <= w_sel_wdata;
    end else begin
      r_rf_wen   <= 1'b0;
    end
  end

  assign iss_stall    = iss_valid & (r_busy[iss_rs1] | r_busy[iss_rs2] | (iss_wen & r_busy[iss_rd]));
  assign w_iss_accept = iss_valid & ~iss_stall;

  // Clear applied before set so a same-cycle set of the same bit wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_rf_wen) w_busy_nxt[r_rf_waddr] = 1'b0;
    if (w_iss_accept && iss_wen && (iss_rd != '0)) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // NOTE: the scoreboard is 32 flops, not a RAM, so resetting it is both cheap and required.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign rf_wen   = r_rf_wen;
  assign rf_waddr = r_rf_waddr;
  assign rf_wdata = r_rf_wdata;
  assign busy     = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writebacks are queued when a grant is
// driven and compared against the RF port one cycle later.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_waddr;
  logic [NREQ*XLEN-1:0] req_wdata;
  logic                 iss_valid;
  logic                 iss_wen;
  logic [AW-1:0]        iss_rd;
  logic [AW-1:0]        iss_rs1;
  logic [AW-1:0]        iss_rs2;
  logic                 iss_stall;
  logic                 rf_wen;
  logic [AW-1:0]        rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic [31:0]          busy;

  typedef struct packed {
    logic            wen;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
  } wb_t;

  wb_t sb_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_waddr (req_waddr),
    .req_wdata (req_wdata),
    .iss_valid (iss_valid),
    .iss_wen   (iss_wen),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    req_waddr[i*AW +: AW]     = a;
    req_wdata[i*XLEN +: XLEN] = d;
  endtask

  task automatic push_exp(input int g);
    wb_t e;
    e.addr = req_waddr[g*AW +: AW];
    e.data = req_wdata[g*XLEN +: XLEN];
    e.wen  = (e.addr != '0);
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pop_check(input string tag);
    wb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed empty scoreboard expected a queued writeback", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_wen"},   64'(rf_wen),   64'(e.wen));
      check({tag, "_waddr"}, 64'(rf_waddr), 64'(e.addr));
      check({tag, "_wdata"}, 64'(rf_wdata), 64'(e.data));
    end
  endtask

  task automatic issue(input logic v, input logic w, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
    iss_valid = v;
    iss_wen   = w;
    iss_rd    = rd;
    iss_rs1   = rs1;
    iss_rs2   = rs2;
  endtask

  initial begin
    int g;
    reset     = 1'b1;
    req_valid = '0;
    req_waddr = '0;
    req_wdata = '0;
    issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    check("rst_busy",  64'(busy),      64'h0);
    check("rst_rfwen", 64'(rf_wen),    64'h0);
    check("rst_waddr", 64'(rf_waddr),  64'h0);
    check("rst_wdata", 64'(rf_wdata),  64'h0);
    check("rst_ready", 64'(req_ready), 64'h0);
    @(posedge clock);
    #1 reset = 1'b0;

    // Round-robin with all sources continuously valid.
    set_src(0, 5'd10, 64'hA0);
    set_src(1, 5'd11, 64'hB1);
    set_src(2, 5'd12, 64'hC2);
    req_valid = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = c % 3;
`endif
      check($sformatf("rr_grant%0d", c), 64'(req_ready), 64'(1) << g);
      push_exp(g);
      tick();
      pop_check($sformatf("rr_wb%0d", c));
    end
    req_valid = '0;
    check("rr_busy", 64'(busy), 64'h0);

    // Issue rd=5, RAW stall, writeback from source 1, stall release.
    issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    #1 check("iss5_stall", 64'(iss_stall), 64'h0);
    tick();
    iss_valid = 1'b0;
    #1 check("iss5_busy", 64'(busy), 64'h20);
    issue(1'b1, 1'b0, 5'd0, 5'd5, 5'd0);
    #1 check("raw5_stall", 64'(iss_stall), 64'h1);
    set_src(1, 5'd5, 64'hDEAD_BEEF);
    req_valid = 3'b010;
    #1 check("wb5_ready", 64'(req_ready), 64'h2);
    push_exp(1);
    tick();
    req_valid = '0;
    pop_check("wb5_t1");
    check("wb5_t1_busy",  64'(busy),      64'h20);
    check("wb5_t1_stall", 64'(iss_stall), 64'h1);
    tick();
    check("wb5_t2_busy",  64'(busy),      64'h0);
    check("wb5_t2_stall", 64'(iss_stall), 64'h0);
    check("wb5_t2_rfwen", 64'(rf_wen),    64'h0);
    iss_valid = 1'b0;

    // x0: issue to rd=0 leaves busy clear, a write to x0 is accepted and dropped.
    issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1 check("x0_iss_stall", 64'(iss_stall), 64'h0);
    tick();
    iss_valid = 1'b0;
    #1 check("x0_busy", 64'(busy), 64'h0);
    set_src(2, 5'd0, 64'h55);
    req_valid = 3'b100;
    #1 check("x0_ready", 64'(req_ready), 64'h4);
    push_exp(2);
    tick();
    req_valid = '0;
    pop_check("x0_wb");

    // WAW hazard on x7.
    issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    #1 check("waw_first_stall", 64'(iss_stall), 64'h0);
    tick();
    iss_valid = 1'b0;
    #1 check("waw_busy", 64'(busy), 64'h80);
    issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    #1 check("waw_stall", 64'(iss_stall), 64'h1);
    iss_wen = 1'b0;
    #1 check("waw_nowen_stall", 64'(iss_stall), 64'h0);
    issue(1'b0, 1'b1, 5'd7, 5'd0, 5'd0);
    #1 check("waw_novalid_stall", 64'(iss_stall), 64'h0);

    // Write 0x1234 to x3, then idle for four cycles.
    set_src(0, 5'd3, 64'h1234);
    req_valid = 3'b001;
    #1 check("x3_ready", 64'(req_ready), 64'h1);
    push_exp(0);
    tick();
    req_valid = '0;
    pop_check("x3_wb");
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("idle%0d_rfwen", c), 64'(rf_wen),   64'h0);
      check($sformatf("idle%0d_waddr", c), 64'(rf_waddr), 64'h3);
      check($sformatf("idle%0d_wdata", c), 64'(rf_wdata), 64'h1234);
    end
    set_src(1, 5'd13, 64'hD1);
    set_src(2, 5'd14, 64'hE2);
    req_valid = 3'b111;
`ifdef RF_ARB_FIXED_PRIO_EN
    #1 check("idle_ptr_grant", 64'(req_ready), 64'h1);
`else
    #1 check("idle_ptr_grant", 64'(req_ready), 64'h2);
`endif
    req_valid = '0;

    // Build busy=0x88 with rf_wen=1, then reset between edges.
    issue(1'b1, 1'b1, 5'd3, 5'd0, 5'd0);
    #1 check("x3_iss_stall", 64'(iss_stall), 64'h0);
    tick();
    iss_valid = 1'b0;
    set_src(2, 5'd9, 64'h99);
    req_valid = 3'b100;
    #1 check("x9_ready", 64'(req_ready), 64'h4);
    push_exp(2);
    tick();
    req_valid = '0;
    pop_check("x9_wb");
    check("pre_rst_busy", 64'(busy), 64'h88);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_busy",  64'(busy),     64'h0);
    check("mid_rst_rfwen", 64'(rf_wen),   64'h0);
    check("mid_rst_waddr", 64'(rf_waddr), 64'h0);
    check("mid_rst_wdata", 64'(rf_wdata), 64'h0);
    req_valid = 3'b111;
    #1 check("mid_rst_ptr_grant", 64'(req_ready), 64'h1);
    req_valid = '0;
    @(posedge clock);
    #1 reset = 1'b0;
    check("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the integer register file's single write port and tracks pending destination registers.
- NREQ writeback sources (ALU, LSU, MDU, …) share the port through valid/ready round-robin arbitration. The winner's write is registered and driven onto the RF write port one cycle later.
- A 32-entry scoreboard marks registers with in-flight writes and stalls issue on RAW/WAW hazards.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- XLEN, 64, data width.
- AW, 5, register address width (32 registers).

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous reset, active-high.
- req_valid  in  NREQ  writeback request per source.
- req_ready  out  NREQ  grant, one-hot or zero.
- req_waddr  in  NREQ*AW  destination register per source, source i at bits [i*AW +: AW].
- req_wdata  in  NREQ*XLEN  write data per source, source i at bits [i*XLEN +: XLEN].
- iss_valid  in  1  instruction presented for issue.
- iss_wen  in  1  issuing instruction writes rd.
- iss_rd  in  AW  destination register.
- iss_rs1  in  AW  source register 1.
- iss_rs2  in  AW  source register 2.
- iss_stall  out  1  issue blocked this cycle.
- rf_wen  out  1  RF write enable.
- rf_waddr  out  AW  RF write address.
- rf_wdata  out  XLEN  RF write data.
- busy  out  32  scoreboard vector; bit r = register r has a pending write.

Behaviour:
- Reset (asynchronous, immediate): busy=0, rr_ptr=0, rf_wen=0, rf_waddr=0, rf_wdata=0. Applies mid-transaction; in-flight writes are dropped.
- Arbitration (combinational):
  - Grant the first i with req_valid[i], scanning cyclically from rr_ptr.
  - req_ready = one-hot of that grant, 0 if no request.
  - req_ready may depend on req_valid; requesters must not make valid depend on ready.
  - At most one transfer per cycle; transfer = req_valid[i] & req_ready[i].
- Pointer: on a transfer by source g, rr_ptr <= (g+1) mod NREQ. Unchanged when idle.
- Write port, 1-cycle latency:
  - On a transfer, the next edge loads rf_waddr/rf_wdata from source g.
  - rf_wen <= (waddr != 0).
  - With no transfer, rf_wen <= 0 and rf_waddr/rf_wdata hold.
  - A write to x0 is accepted (ready=1) and then discarded.
- Scoreboard:
  - Issue accept = iss_valid & ~iss_stall.
  - Set busy[iss_rd] on an accepted issue with iss_wen=1 and iss_rd != 0.
  - Clear busy[rf_waddr] on every edge where rf_wen=1, so the RF holds the new value from the following cycle.
  - Set and clear of the same bit in one cycle: set wins. This only arises for a writeback to a non-busy register.
  - Writeback to a non-busy register still writes the RF; busy is unchanged.
  - busy[0] is always 0.
- Stall: iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_wen & busy[iss_rd])). Combinational; 0 when iss_valid=0.
- Latency, requester to RF update: transfer at cycle T, rf_wen high in T+1, register readable in T+2, busy bit clear in T+2.

Optional Feature:
- Macro RF_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is removed and tied to 0.
- Undefined (default): round-robin as above.

Test Plan:
- Reset mid-stream: busy=0x0000_0088, rf_wen=1, assert reset asynchronously between edges -> all outputs 0 immediately, before the next clock edge.
- Issue then writeback: issue rd=5 wen=1 -> busy[5]=1. Next issue rs1=5 -> iss_stall=1. Source 1 sends waddr=5 wdata=0xDEAD_BEEF at T -> rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in T+1; busy[5]=0 and stall=0 in T+2.
- Round-robin: all three sources valid continuously, distinct addresses -> grants 0,1,2,0,1,2. Define RF_ARB_FIXED_PRIO_EN -> grants 0,0,0 while source 0 stays valid.
- x0 handling: issue rd=0 wen=1 -> busy stays 0. Source 2 writes waddr=0 -> req_ready[2]=1, rf_wen=0 next cycle.
- WAW hazard: busy[7]=1, issue iss_wen=1 rd=7 with rs1=rs2=0 -> iss_stall=1. Same issue with iss_wen=0 -> iss_stall=0.
- Idle hold: no requests for 4 cycles after a write of 0x1234 to x3 -> rf_wen=0, rf_waddr=3, rf_wdata=0x1234 held, rr_ptr unchanged.
